// File: rtl/pass_update_ctrl.sv
// Rolling-password update controller downstream of the password checker.
// Optional timed lockout after repeated failures is built when PASS_LOCKOUT_EN is defined.
module pass_update_ctrl #(
  parameter logic [31:0] SEED           = 32'h1D2C3B4A,
  parameter int          OPEN_CYCLES    = 16,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        checkReq,
  input  logic        unlockDoor,
  input  logic        readLock,
  input  logic        readKey,
  input  logic        lockAck,
  input  logic        keyAck,
  output logic [31:0] newPass,
  output logic        writeLock,
  output logic        writeKey,
  output logic        doorOpen,
  output logic        lockout,
  output logic        busy,
  output logic [3:0]  failCount
);

  // state   | meaning
  // IDLE    | waiting for checkReq
  // EVAL    | sample checker result, update failCount
  // GEN     | advance LFSR to the next password
  // WR_LOCK | writeLock request until lockAck
  // WR_KEY  | writeKey request until keyAck
  // OPEN    | doorOpen for OPEN_CYCLES clocks
  // LOCKOUT | lockout for LOCKOUT_CYCLES clocks (PASS_LOCKOUT_EN only)
  typedef enum logic [2:0] {
    IDLE, EVAL, GEN, WR_LOCK, WR_KEY, OPEN
`ifdef PASS_LOCKOUT_EN
    , LOCKOUT
`endif
  } state_t;

  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [31:0]   POLY      = 32'h80200003;

  if (SEED == 32'h0 || OPEN_CYCLES < 1 || MAX_FAILS < 1 || MAX_FAILS > 15 || LOCKOUT_CYCLES < 1)
  begin : gBadParams
    $error("pass_update_ctrl: illegal parameter value");
  end

`ifdef PASS_LOCKOUT_EN
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    MAX_CNT   = 4'(MAX_FAILS);
`endif

  state_t        state, stateNext;
  logic [TW-1:0] timerCnt;
  logic          match;
  logic [3:0]    failNext;
  logic [31:0]   lfsrShift, lfsrNext;
  logic          lockHit;

  assign match     = unlockDoor & ~readLock & ~readKey;
  assign failNext  = (failCount == 4'hF) ? 4'hF : failCount + 4'd1;
  assign lfsrShift = {1'b0, newPass[31:1]} ^ (newPass[0] ? POLY : 32'h0);
  assign lfsrNext  = (lfsrShift == 32'h0) ? SEED : lfsrShift;
`ifdef PASS_LOCKOUT_EN
  assign lockHit   = (failNext >= MAX_CNT);
`else
  assign lockHit   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    writeLock = 1'b0;
    writeKey  = 1'b0;
    doorOpen  = 1'b0;
    lockout   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (checkReq) stateNext = EVAL;
      EVAL: begin
        if (match)        stateNext = GEN;
`ifdef PASS_LOCKOUT_EN
        else if (lockHit) stateNext = LOCKOUT;
`endif
        else              stateNext = IDLE;
      end
      GEN:     stateNext = WR_LOCK;
      WR_LOCK: begin
        writeLock = 1'b1;
        if (lockAck) stateNext = WR_KEY;
      end
      WR_KEY: begin
        writeKey = 1'b1;
        if (keyAck) stateNext = OPEN;
      end
      OPEN: begin
        doorOpen = 1'b1;
        if (timerCnt == '0) stateNext = IDLE;
      end
`ifdef PASS_LOCKOUT_EN
      LOCKOUT: begin
        lockout = 1'b1;
        if (timerCnt == '0) stateNext = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  // One timer serves OPEN and LOCKOUT; it is loaded on entry and runs down to terminal count.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      newPass   <= SEED;
      failCount <= 4'd0;
      timerCnt  <= '0;
    end else begin
      if (state == EVAL) failCount <= match ? 4'd0 : failNext;
      if (state == GEN)  newPass   <= lfsrNext;
`ifdef PASS_LOCKOUT_EN
      if (state == LOCKOUT && timerCnt == '0) failCount <= 4'd0;
`endif
      if (state == WR_KEY && keyAck)
        timerCnt <= OPEN_LOAD;
`ifdef PASS_LOCKOUT_EN
      else if (state == EVAL && !match && lockHit)
        timerCnt <= LOCK_LOAD;
`endif
      else if (timerCnt != '0)
        timerCnt <= timerCnt - 1'b1;
    end
  end

endmodule
